// File: rtl/time_uart_scheduler.sv
// Sends "HH:MM:SS\r\n" on a shared UART, arbitrating the transmitter against the RX echo path.
// The time is snapshotted at message start, so digit changes mid-message never tear the output.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | arbitrate between pending report and echo byte
// S_LOAD  | place report char(char_idx) into tx_data
// S_START | wait for transmitter idle, then pulse tx_start
// S_WAIT_HI | wait for transmitter to accept (tx_busy rises)
// S_WAIT_LO | wait for byte done; advance char, finish, or end echo
module time_uart_scheduler #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SEP_CHAR   = 8'h3A,
  parameter logic [DATA_WIDTH-1:0] BAD_CHAR   = 8'h3F
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [3:0]            sec0_i,
  input  logic [3:0]            sec1_i,
  input  logic [3:0]            min0_i,
  input  logic [3:0]            min1_i,
  input  logic [3:0]            hour0_i,
  input  logic [3:0]            hour1_i,
  input  logic                  auto_en_i,
  input  logic                  report_req_i,
  input  logic                  echo_valid_i,
  input  logic [DATA_WIDTH-1:0] echo_data_i,
  output logic                  echo_ready_o,
  input  logic                  tx_busy_i,
  output logic                  tx_start_o,
  output logic [DATA_WIDTH-1:0] tx_data_o,
  output logic                  busy_o,
  output logic                  msg_done_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT_HI, S_WAIT_LO} state_t;

  localparam logic GRANT_ECHO   = 1'b0;
  localparam logic GRANT_REPORT = 1'b1;

  state_t                state_q, state_d;
  logic                  pending_q, pending_d;
  logic                  last_grant_q, last_grant_d;
  logic                  is_echo_q, is_echo_d;
  logic [3:0]            char_idx_q, char_idx_d;
  logic [23:0]           snap_q, snap_d;
  logic [3:0]            prev_sec0_q;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

  logic                  trig;
  logic                  grant_report;
  logic                  grant_echo;
  logic [DATA_WIDTH-1:0] char_sel;

  function automatic logic [DATA_WIDTH-1:0] digit_char(input logic [3:0] d);
    if (d > 4'd9) return BAD_CHAR;
    return DATA_WIDTH'({4'h3, d});
  endfunction

  assign trig = report_req_i | (auto_en_i & (sec0_i != prev_sec0_q));
  // Contention alternates on last_grant; grants are mutually exclusive by construction.
  assign grant_report = pending_q & (~echo_valid_i | (last_grant_q == GRANT_ECHO));
  assign grant_echo   = echo_valid_i & (~pending_q | (last_grant_q == GRANT_REPORT));

  always_comb begin
    char_sel = '0;
    case (char_idx_q)
      4'd0:       char_sel = digit_char(snap_q[23:20]);
      4'd1:       char_sel = digit_char(snap_q[19:16]);
      4'd2, 4'd5: char_sel = SEP_CHAR;
      4'd3:       char_sel = digit_char(snap_q[15:12]);
      4'd4:       char_sel = digit_char(snap_q[11:8]);
      4'd6:       char_sel = digit_char(snap_q[7:4]);
      4'd7:       char_sel = digit_char(snap_q[3:0]);
      4'd8:       char_sel = DATA_WIDTH'(8'h0D);
      4'd9:       char_sel = DATA_WIDTH'(8'h0A);
      default:    char_sel = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    last_grant_d = last_grant_q;
    is_echo_d    = is_echo_q;
    char_idx_d   = char_idx_q;
    snap_d       = snap_q;
    tx_data_d    = tx_data_q;
    echo_ready_o = 1'b0;
    tx_start_o   = 1'b0;
    msg_done_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_report) begin
          snap_d     = {hour1_i, hour0_i, min1_i, min0_i, sec1_i, sec0_i};
          char_idx_d = 4'd0;
          pending_d  = 1'b0;
          is_echo_d  = 1'b0;
          state_d    = S_LOAD;
        end else if (grant_echo) begin
          echo_ready_o = 1'b1;
          tx_data_d    = echo_data_i;
          last_grant_d = GRANT_ECHO;
          is_echo_d    = 1'b1;
          state_d      = S_START;
        end
      end
      S_LOAD: begin
        tx_data_d    = char_sel;
        last_grant_d = GRANT_REPORT;
        state_d      = S_START;
      end
      S_START: begin
        if (!tx_busy_i) begin
          tx_start_o = 1'b1;
          state_d    = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (tx_busy_i) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!tx_busy_i) begin
          if (is_echo_q) begin
            state_d = S_IDLE;
          end else if (char_idx_q < 4'd9) begin
            char_idx_d = char_idx_q + 4'd1;
            state_d    = S_LOAD;
          end else begin
            msg_done_o = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (trig) pending_d = 1'b1;

    // Pulses must not leak out while reset is being applied.
    if (rst_i) begin
      echo_ready_o = 1'b0;
      tx_start_o   = 1'b0;
      msg_done_o   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    prev_sec0_q <= sec0_i;
    if (rst_i) begin
      state_q      <= S_IDLE;
      pending_q    <= 1'b0;
      last_grant_q <= GRANT_ECHO;
      is_echo_q    <= 1'b0;
      char_idx_q   <= 4'd0;
      snap_q       <= '0;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      is_echo_q    <= is_echo_d;
      char_idx_q   <= char_idx_d;
      snap_q       <= snap_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign tx_data_o = tx_data_q;
  assign busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_time_uart_scheduler.sv
// Directed bench for time_uart_scheduler with a simple transmitter model (busy for 20 cycles per byte).
// Captures every started byte into a queue and compares against hand-written expected strings.
module tb_time_uart_scheduler;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] sec0_i = 4'd6, sec1_i = 4'd5, min0_i = 4'd4, min1_i = 4'd3;
  logic [3:0] hour0_i = 4'd2, hour1_i = 4'd1;
  logic       auto_en_i = 1'b0;
  logic       report_req_i = 1'b0;
  logic       echo_valid_i = 1'b0;
  logic [7:0] echo_data_i = 8'h00;
  logic       echo_ready_o;
  logic       tx_busy_i;
  logic       tx_start_o;
  logic [7:0] tx_data_o;
  logic       busy_o;
  logic       msg_done_o;

  logic       force_busy = 1'b0;
  logic [4:0] busy_cnt = '0;

  logic [7:0] got[$];
  int         n_done = 0;
  int         hold_err = 0;
  logic       in_flight = 1'b0;
  logic [7:0] held = '0;

  int         n_chk = 0;
  int         n_fail = 0;

  time_uart_scheduler dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .sec0_i       (sec0_i),
    .sec1_i       (sec1_i),
    .min0_i       (min0_i),
    .min1_i       (min1_i),
    .hour0_i      (hour0_i),
    .hour1_i      (hour1_i),
    .auto_en_i    (auto_en_i),
    .report_req_i (report_req_i),
    .echo_valid_i (echo_valid_i),
    .echo_data_i  (echo_data_i),
    .echo_ready_o (echo_ready_o),
    .tx_busy_i    (tx_busy_i),
    .tx_start_o   (tx_start_o),
    .tx_data_o    (tx_data_o),
    .busy_o       (busy_o),
    .msg_done_o   (msg_done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_start_o) busy_cnt <= 5'd20;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 5'd1;
  end
  assign tx_busy_i = (busy_cnt != 0) | force_busy;

  always @(negedge clk) begin
    if (tx_start_o) got.push_back(tx_data_o);
    if (msg_done_o) n_done++;
    if (rst_i) in_flight = 1'b0;
    else if (tx_start_o) begin
      in_flight = 1'b1;
      held = tx_data_o;
    end else if (!tx_busy_i) in_flight = 1'b0;
    else if (in_flight && tx_data_o != held) hold_err++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    report_req_i = 1'b1;
    step();
    report_req_i = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int c = 0;
    while (got.size() < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check_eq(tag, got.size(), n);
  endtask

  task automatic quiet(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_str(input int base, input string s, input string tag);
    for (int i = 0; i < s.len(); i++)
      check_eq($sformatf("%s_c%0d", tag, i),
               (base + i < got.size()) ? 32'(got[base + i]) : 32'hFFFF_FFFF, 32'(s[i]));
  endtask

  task automatic send_echo(input logic [7:0] d, input string tag);
    int c = 0;
    echo_data_i  = d;
    echo_valid_i = 1'b1;
    @(negedge clk);
    while (!echo_ready_o && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check_eq(tag, echo_ready_o, 1'b1);
    step();
    echo_valid_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, md, k;

    repeat (3) step();
    rst_i = 1'b0;
    @(negedge clk);
    check_eq("rst_tx_start", tx_start_o, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_msg_done", msg_done_o, 1'b0);
    check_eq("rst_echo_ready", echo_ready_o, 1'b0);
    check_eq("rst_tx_data", tx_data_o, 8'h00);

    // T1: basic message plus grant-to-start latency
    step();
    base = got.size();
    md = n_done;
    pulse_req();
    k = 0;
    while (!tx_start_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("t1_latency", k, 3);
    check_eq("t1_busy", busy_o, 1'b1);
    wait_bytes(base + 10, "t1_count");
    quiet(30);
    check_str(base, "12:34:56\r\n", "t1");
    check_eq("t1_msg_done", n_done - md, 1);
    check_eq("t1_idle", busy_o, 1'b0);

    // T2: live digits change mid-message; auto_en triggers a follow-up
    step();
    sec0_i = 4'd5;
    repeat (3) step();
    auto_en_i = 1'b1;
    base = got.size();
    md = n_done;
    pulse_req();
    wait_bytes(base + 4, "t2_mid");
    step();
    sec0_i = 4'd6;
    min0_i = 4'd5;
    wait_bytes(base + 20, "t2_count");
    quiet(30);
    auto_en_i = 1'b0;
    check_str(base, "12:34:55\r\n", "t2a");
    check_str(base + 10, "12:35:56\r\n", "t2b");
    quiet(300);
    check_eq("t2_no_third", got.size(), base + 20);
    check_eq("t2_msg_done", n_done - md, 2);

    // T3: repeated requests during a message coalesce into one
    step();
    min0_i = 4'd4;
    base = got.size();
    md = n_done;
    pulse_req();
    wait_bytes(base + 2, "t3_a");
    pulse_req();
    wait_bytes(base + 5, "t3_b");
    pulse_req();
    wait_bytes(base + 8, "t3_c");
    pulse_req();
    wait_bytes(base + 20, "t3_count");
    quiet(400);
    check_eq("t3_exact", got.size(), base + 20);
    check_eq("t3_msg_done", n_done - md, 2);
    check_str(base, "12:34:56\r\n", "t3a");
    check_str(base + 10, "12:34:56\r\n", "t3b");

    // T4a: echo arriving mid-message waits, then alternates with pending report
    step();
    base = got.size();
    pulse_req();
    wait_bytes(base + 3, "t4_mid");
    step();
    pulse_req();
    send_echo(8'h41, "t4_echo_accept");
    wait_bytes(base + 21, "t4_count");
    quiet(30);
    check_str(base, "12:34:56\r\n", "t4a");
    check_eq("t4_echo_byte", got[base + 10], 8'h41);
    check_str(base + 11, "12:34:56\r\n", "t4b");

    // T4b: echo and request together from reset -> echo first
    step();
    rst_i = 1'b1;
    step();
    step();
    base = got.size();
    rst_i = 1'b0;
    echo_data_i = 8'h42;
    echo_valid_i = 1'b1;
    report_req_i = 1'b1;
    @(negedge clk);
    check_eq("t4b_echo_ready", echo_ready_o, 1'b1);
    step();
    report_req_i = 1'b0;
    echo_valid_i = 1'b0;
    wait_bytes(base + 11, "t4b_count");
    quiet(30);
    check_eq("t4b_first", got[base], 8'h42);
    check_str(base + 1, "12:34:56\r\n", "t4b");

    // T5: bad digit and transmitter held busy at START
    step();
    hour1_i = 4'hA;
    base = got.size();
    force_busy = 1'b1;
    pulse_req();
    quiet(12);
    check_eq("t5_no_start", got.size(), base);
    check_eq("t5_busy", busy_o, 1'b1);
    step();
    force_busy = 1'b0;
    wait_bytes(base + 10, "t5_count");
    quiet(30);
    check_str(base, "?2:34:56\r\n", "t5");
    hour1_i = 4'd1;

    // T6: reset mid-message aborts; a fresh request restarts at char 0
    step();
    base = got.size();
    md = n_done;
    pulse_req();
    wait_bytes(base + 6, "t6_mid");
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk);
    check_eq("t6_tx_start", tx_start_o, 1'b0);
    check_eq("t6_busy", busy_o, 1'b0);
    check_eq("t6_msg_done", msg_done_o, 1'b0);
    check_eq("t6_tx_data", tx_data_o, 8'h00);
    quiet(60);
    check_eq("t6_aborted", got.size(), base + 6);
    check_eq("t6_no_done", n_done - md, 0);
    step();
    pulse_req();
    wait_bytes(base + 16, "t6_count");
    quiet(30);
    check_eq("t6_restart", got[base + 6], 8'h31);
    check_str(base + 6, "12:34:56\r\n", "t6");
    check_eq("t6_done", n_done - md, 1);

    check_eq("tx_data_hold", hold_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
